// File: rtl/muldiv_seq.sv
// Iterative RV M-extension multiply/divide unit: shift-add multiply, restoring divide on magnitudes.
// Latency XLEN+1 cycles (divide-by-zero/overflow: 1); req_i is ignored while busy_o=1, no queueing.
module muldiv_seq #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [2:0]        op_i,
    input  logic [XLEN-1:0]   data1_i,
    input  logic [XLEN-1:0]   data2_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              res_valid_o,
    output logic [XLEN-1:0]   res_o,
    output logic [ADDR_W-1:0] wr_addr_o
);

    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] LAST_ITER = XLEN'(XLEN-1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     opa_q;
    logic [XLEN-1:0]     hi_q;
    logic [XLEN-1:0]     lo_q;
    logic                neg_q;
    logic                rneg_q;
    logic [ADDR_W-1:0]   tag_q;
    logic [XLEN-1:0]     cnt_q;
    logic                busy_q;
    logic [XLEN-1:0]     res_q;
    logic [ADDR_W-1:0]   wr_addr_q;

    logic                accept;
    logic                is_div;
    logic                sgn1, sgn2;
    logic [XLEN-1:0]     mag1, mag2;
    logic                div_zero, div_ovf, special;
    logic [XLEN-1:0]     special_res;

    logic [XLEN:0]       sum;
    logic [XLEN:0]       shifted;
    logic [XLEN:0]       diff;
    logic [XLEN-1:0]     hi_n, lo_n;
    logic [2*XLEN-1:0]   prod, prod_s;
    logic [XLEN-1:0]     mul_res, div_res, final_res;
    logic                last_iter;

    // Request decode: magnitudes, sign flags, and the single-cycle special cases.
    always_comb begin
        is_div      = op_i[2];
        sgn1        = data1_i[XLEN-1] & (is_div ? ~op_i[0] : (op_i[1:0] != 2'b11));
        sgn2        = data2_i[XLEN-1] & (is_div ? ~op_i[0] : ~op_i[1]);
        mag1        = sgn1 ? -data1_i : data1_i;
        mag2        = sgn2 ? -data2_i : data2_i;
        div_zero    = is_div && (data2_i == '0);
        div_ovf     = is_div && !op_i[0] && (data1_i == MIN_NEG) && (data2_i == '1);
        special     = div_zero || div_ovf;
        if (div_zero) begin
            special_res = op_i[1] ? data1_i : '1;
        end else begin
            special_res = op_i[1] ? '0 : MIN_NEG;
        end
        accept      = (state_q == IDLE) && req_i && !flush_i;
    end

    // One iteration: multiply uses hi:lo as the shifting product, divide as remainder:quotient.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, opa_q};
        if (op_q[2]) begin
            hi_n = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], ~diff[XLEN]};
        end else begin
            hi_n = sum[XLEN:1];
            lo_n = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod      = {hi_n, lo_n};
        prod_s    = neg_q ? -prod : prod;
        mul_res   = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        if (op_q[1]) begin
            div_res = rneg_q ? -hi_n : hi_n;
        end else begin
            div_res = neg_q ? -lo_n : lo_n;
        end
        final_res = op_q[2] ? div_res : mul_res;
        last_iter = (state_q == CALC) && (cnt_q == LAST_ITER) && !flush_i;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            opa_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            tag_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            res_q     <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            if (accept) begin
                op_q   <= op_i;
                opa_q  <= is_div ? mag2 : mag1;
                hi_q   <= '0;
                lo_q   <= is_div ? mag1 : mag2;
                neg_q  <= sgn1 ^ sgn2;
                rneg_q <= sgn1;
                tag_q  <= wr_addr_i;
                cnt_q  <= '0;
                if (special) begin
                    res_q     <= special_res;
                    wr_addr_q <= wr_addr_i;
                end
            end else if (state_q == CALC) begin
                hi_q  <= hi_n;
                lo_q  <= lo_n;
                cnt_q <= cnt_q + XLEN'(1);
                if (last_iter) begin
                    res_q     <= final_res;
                    wr_addr_q <= tag_q;
                end
            end
        end
    end

    // A flush landing in the DONE cycle must still kill the strobe.
    assign res_valid_o = (state_q == DONE) && !flush_i;
    assign busy_o      = busy_q;
    assign res_o       = res_q;
    assign wr_addr_o   = wr_addr_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq at XLEN=8, 32 and 64 sharing one stimulus bus.
module tb_muldiv_seq;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [2:0]  op;
    logic [63:0] d1, d2;
    logic [4:0]  tag;
    logic        req8, req32, req64;

    logic        busy8, valid8;
    logic [7:0]  res8;
    logic [4:0]  addr8;
    logic        busy32, valid32;
    logic [31:0] res32;
    logic [4:0]  addr32;
    logic        busy64, valid64;
    logic [63:0] res64;
    logic [4:0]  addr64;

    int n_chk  = 0;
    int n_fail = 0;
    int sel    = 32;

    logic        obs_busy, obs_valid;
    logic [63:0] obs_res;
    logic [4:0]  obs_addr;

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(8), .ADDR_W(5)) u_dut8 (
        .clk(clk), .rst(rst), .req_i(req8), .op_i(op),
        .data1_i(d1[7:0]), .data2_i(d2[7:0]), .wr_addr_i(tag), .flush_i(flush),
        .busy_o(busy8), .res_valid_o(valid8), .res_o(res8), .wr_addr_o(addr8)
    );

    muldiv_seq #(.XLEN(32), .ADDR_W(5)) u_dut32 (
        .clk(clk), .rst(rst), .req_i(req32), .op_i(op),
        .data1_i(d1[31:0]), .data2_i(d2[31:0]), .wr_addr_i(tag), .flush_i(flush),
        .busy_o(busy32), .res_valid_o(valid32), .res_o(res32), .wr_addr_o(addr32)
    );

    muldiv_seq #(.XLEN(64), .ADDR_W(5)) u_dut64 (
        .clk(clk), .rst(rst), .req_i(req64), .op_i(op),
        .data1_i(d1), .data2_i(d2), .wr_addr_i(tag), .flush_i(flush),
        .busy_o(busy64), .res_valid_o(valid64), .res_o(res64), .wr_addr_o(addr64)
    );

    always_comb begin
        obs_busy  = busy32;
        obs_valid = valid32;
        obs_res   = {32'h0, res32};
        obs_addr  = addr32;
        if (sel == 8) begin
            obs_busy  = busy8;
            obs_valid = valid8;
            obs_res   = {56'h0, res8};
            obs_addr  = addr8;
        end else if (sel == 64) begin
            obs_busy  = busy64;
            obs_valid = valid64;
            obs_res   = res64;
            obs_addr  = addr64;
        end
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Call at a negedge: presents the request, waits for the strobe, checks it all.
    task automatic issue(input int w, input logic [2:0] o, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] t, input logic [63:0] exp,
                         input int exp_lat, input string name);
        int lat;
        int busy_cnt;
        sel   = w;
        op    = o;
        d1    = a;
        d2    = b;
        tag   = t;
        req8  = (w == 8);
        req32 = (w == 32);
        req64 = (w == 64);
        @(negedge clk);
        req8     = 1'b0;
        req32    = 1'b0;
        req64    = 1'b0;
        lat      = 1;
        busy_cnt = obs_busy ? 1 : 0;
        while (!obs_valid && lat < 200) begin
            @(negedge clk);
            lat++;
            if (obs_busy) busy_cnt++;
        end
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check({name, "_res"}, obs_res, exp);
        check({name, "_addr"}, 64'(obs_addr), 64'(t));
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
        @(negedge clk);
        check({name, "_strobe_end"}, 64'(obs_valid), 64'(0));
        check({name, "_idle"}, 64'(obs_busy), 64'(0));
    endtask

    initial begin
        int spurious;
        int first;
        int second;

        rst   = 1'b1;
        flush = 1'b0;
        req8  = 1'b0;
        req32 = 1'b0;
        req64 = 1'b0;
        op    = OP_MUL;
        d1    = '0;
        d2    = '0;
        tag   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy32", 64'(busy32), 64'(0));
        check("rst_valid32", 64'(valid32), 64'(0));
        check("rst_res32", 64'(res32), 64'(0));
        check("rst_addr32", 64'(addr32), 64'(0));
        check("rst_res8", 64'(res8), 64'(0));
        check("rst_res64", res64, 64'(0));
        rst = 1'b0;

        // First accept lands on the first edge with rst low.
        issue(32, OP_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFEB, 33, "mul32");
        issue(32, OP_MULH,   64'h8000_0000, 64'h8000_0000, 5'd1, 64'h4000_0000, 33, "mulh");
        issue(32, OP_MULHSU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd2, 64'hFFFF_FFFF, 33, "mulhsu");
        issue(32, OP_MULHU,  64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd3, 64'hFFFF_FFFE, 33, "mulhu");
        issue(32, OP_MUL,    64'd0, 64'h1234, 5'd4, 64'h0, 33, "mul_zero");
        issue(32, OP_DIV,    64'hFFFF_FFF9, 64'd2, 5'd6, 64'hFFFF_FFFD, 33, "div_neg");
        issue(32, OP_REM,    64'hFFFF_FFF9, 64'd2, 5'd7, 64'hFFFF_FFFF, 33, "rem_neg");
        issue(32, OP_DIVU,   64'hFFFF_FFFF, 64'd2, 5'd8, 64'h7FFF_FFFF, 33, "divu");
        issue(32, OP_DIV,    64'd100, 64'hFFFF_FFF9, 5'd9, 64'hFFFF_FFF2, 33, "div_negdivisor");
        issue(32, OP_REM,    64'hFFFF_FF9C, 64'd7, 5'd10, 64'hFFFF_FFFE, 33, "rem_negdividend");
        issue(32, OP_REMU,   64'd100, 64'd7, 5'd11, 64'd2, 33, "remu");
        issue(32, OP_DIV,    64'd5, 64'd0, 5'd12, 64'hFFFF_FFFF, 1, "div_by_zero");
        issue(32, OP_REMU,   64'd5, 64'd0, 5'd13, 64'd5, 1, "remu_by_zero");
        issue(32, OP_DIV,    64'h8000_0000, 64'hFFFF_FFFF, 5'd14, 64'h8000_0000, 1, "div_ovf");
        issue(32, OP_REM,    64'h8000_0000, 64'hFFFF_FFFF, 5'd15, 64'h0, 1, "rem_ovf");

        // Flush part-way through CALC: no strobe, outputs keep the previous result tag.
        sel   = 32;
        op    = OP_MUL;
        d1    = 64'd123;
        d2    = 64'd456;
        tag   = 5'd20;
        req32 = 1'b1;
        @(negedge clk);
        req32 = 1'b0;
        spurious = 0;
        repeat (9) begin
            @(negedge clk);
            if (valid32) spurious++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy32), 64'(0));
        repeat (40) begin
            @(negedge clk);
            if (valid32) spurious++;
        end
        check("flush_no_strobe", 64'(spurious), 64'(0));
        check("flush_addr_hold", 64'(addr32), 64'(15));
        issue(32, OP_DIVU, 64'd100, 64'd7, 5'd3, 64'd14, 33, "after_flush");

        // Flush and request together in IDLE: flush wins.
        op    = OP_MUL;
        d1    = 64'd9;
        d2    = 64'd9;
        tag   = 5'd21;
        req32 = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        req32 = 1'b0;
        flush = 1'b0;
        check("flush_req_busy", 64'(busy32), 64'(0));
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid32) spurious++;
        end
        check("flush_req_no_strobe", 64'(spurious), 64'(0));

        // Held request: ignored while busy, re-accepted the cycle after DONE.
        op     = OP_MUL;
        d1     = 64'd3;
        d2     = 64'd5;
        tag    = 5'd1;
        req32  = 1'b1;
        first  = 0;
        second = 0;
        for (int c = 1; c <= 120 && second == 0; c++) begin
            @(negedge clk);
            if (valid32) begin
                if (first == 0) begin
                    first = c;
                end else begin
                    second = c;
                    req32  = 1'b0;
                end
            end
        end
        req32 = 1'b0;
        check("b2b_first_lat", 64'(first), 64'(33));
        check("b2b_interval", 64'(second - first), 64'(34));
        check("b2b_res", 64'(res32), 64'(15));
        @(negedge clk);
        check("b2b_idle", 64'(busy32), 64'(0));

        // Reset mid-CALC with a request on the reset edge, then accept on the first free edge.
        op    = OP_MUL;
        d1    = 64'd7;
        d2    = 64'd11;
        tag   = 5'd12;
        req32 = 1'b1;
        @(negedge clk);
        req32 = 1'b0;
        repeat (10) @(negedge clk);
        rst   = 1'b1;
        op    = OP_DIVU;
        d1    = 64'd100;
        d2    = 64'd7;
        tag   = 5'd6;
        req32 = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(busy32), 64'(0));
        check("midrst_valid", 64'(valid32), 64'(0));
        check("midrst_res", 64'(res32), 64'(0));
        check("midrst_addr", 64'(addr32), 64'(0));
        rst = 1'b0;
        issue(32, OP_DIVU, 64'd100, 64'd7, 5'd6, 64'd14, 33, "post_rst");

        issue(8,  OP_MUL,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hEB, 9, "mul8");
        issue(8,  OP_MULH, 64'h80, 64'h80, 5'd2, 64'h40, 9, "mulh8");
        issue(8,  OP_DIV,  64'h80, 64'hFF, 5'd3, 64'h80, 1, "div_ovf8");
        issue(64, OP_MUL,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 65, "mul64");
        issue(64, OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4,
              64'hFFFF_FFFF_FFFF_FFFE, 65, "mulhu64");
        issue(64, OP_DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div64");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
